// File: rtl/simon_pkg.sv
// Shared types and default dimensions for the SIMON_9696 host controller.
package simon_pkg;

    localparam int SIMON_N = 48;
    localparam int SIMON_M = 2;
    localparam int BLK_W   = 2 * SIMON_N;
    localparam int KEY_W   = SIMON_M * SIMON_N;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY_REQ,
        ST_KEY_WAIT,
        ST_DAT_REQ,
        ST_DAT_WAIT,
        ST_READ,
        ST_OUT
    } simon_host_state_t;

endpackage

// File: rtl/simon_watchdog.sv
// Per-phase watchdog: counts enabled cycles since the last clear and flags
// expiry on the TO-th consecutive cycle spent in one waiting state.
module simon_watchdog #(
    parameter int TO = 1024
) (
    input  logic clk,
    input  logic nR,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TO + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!nR) begin
            cnt <= '0;
        end else if (clear || !enable) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // cnt holds the number of completed cycles, so TO-1 marks the TO-th cycle
    assign expired = enable && (cnt == CW'(TO - 1));

endmodule

// File: rtl/simon_host_ctrl.sv
// Host-side initiator for the SIMON_9696 core: valid/ready front end, core
// key/data handshake sequencing, result capture and valid/ready back end.
//
// state       | meaning
// ST_IDLE     | waiting for a key or block request
// ST_KEY_REQ  | newKey asserted, waiting for ldKey
// ST_KEY_WAIT | key latched by core, waiting for doneKey
// ST_DAT_REQ  | newData asserted, waiting for ldData
// ST_DAT_WAIT | block latched by core, waiting for doneData
// ST_READ     | readData asserted, waiting for doneData to drop
// ST_OUT      | result presented downstream, waiting for res_ready
module simon_host_ctrl
    import simon_pkg::*;
#(
    parameter int N  = SIMON_N,
    parameter int M  = SIMON_M,
    parameter int TO = 1024
) (
    input  logic           clk,
    input  logic           nR,
    input  logic           key_valid,
    input  logic [M*N-1:0] key_in,
    output logic           key_ready,
    input  logic           blk_valid,
    input  logic [2*N-1:0] blk_in,
    input  logic           blk_enc,
    output logic           blk_ready,
    output logic           res_valid,
    output logic [2*N-1:0] res_data,
    input  logic           res_ready,
    output logic           err,
    output logic           newKey,
    output logic [M*N-1:0] key,
    input  logic           ldKey,
    input  logic           doneKey,
    output logic           newData,
    output logic [2*N-1:0] plain,
    output logic           enc_dec,
    input  logic           ldData,
    input  logic           doneData,
    output logic           readData,
    input  logic [2*N-1:0] cipher
);

    simon_host_state_t state_q;
    simon_host_state_t state_d;
    logic              key_loaded;
    logic              wd_clear;
    logic              wd_enable;
    logic              wd_expired;

    always_ff @(posedge clk) begin
        if (!nR) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    state_d = ST_KEY_REQ;
                end else if (blk_valid && key_loaded) begin
                    state_d = ST_DAT_REQ;
                end
            end
            ST_KEY_REQ:  if (ldKey)     state_d = ST_KEY_WAIT;
            ST_KEY_WAIT: if (doneKey)   state_d = ST_IDLE;
            ST_DAT_REQ:  if (ldData)    state_d = ST_DAT_WAIT;
            ST_DAT_WAIT: if (doneData)  state_d = ST_READ;
            ST_READ:     if (!doneData) state_d = ST_OUT;
            ST_OUT:      if (res_ready) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
        // A stuck core abandons the whole operation; the result is discarded
        if (wd_expired) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        key_ready = 1'b0;
        blk_ready = 1'b0;
        newKey    = 1'b0;
        newData   = 1'b0;
        readData  = 1'b0;
        res_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                key_ready = nR && key_valid;
                blk_ready = nR && !key_valid && blk_valid && key_loaded;
            end
            ST_KEY_REQ: newKey    = 1'b1;
            ST_DAT_REQ: newData   = 1'b1;
            ST_READ:    readData  = 1'b1;
            ST_OUT:     res_valid = 1'b1;
            default: ;
        endcase
    end

    assign wd_enable = (state_q == ST_KEY_REQ)  || (state_q == ST_KEY_WAIT) ||
                       (state_q == ST_DAT_REQ)  || (state_q == ST_DAT_WAIT) ||
                       (state_q == ST_READ);
    assign wd_clear  = (state_d != state_q);

    simon_watchdog #(
        .TO (TO)
    ) u_watchdog (
        .clk     (clk),
        .nR      (nR),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!nR) begin
            key_loaded <= 1'b0;
            err        <= 1'b0;
            key        <= '0;
            plain      <= '0;
            enc_dec    <= 1'b0;
            res_data   <= '0;
        end else begin
            if (key_ready) begin
                key        <= key_in;
                key_loaded <= 1'b0;
            end
            if (blk_ready) begin
                plain   <= blk_in;
                enc_dec <= blk_enc;
            end
            if ((state_q == ST_KEY_WAIT) && doneKey && !wd_expired) begin
                key_loaded <= 1'b1;
            end
            if ((state_q == ST_DAT_WAIT) && doneData && !wd_expired) begin
                res_data <= cipher;
            end
            if (wd_expired) begin
                err        <= 1'b1;
                key_loaded <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_simon_host_ctrl.sv
// Directed bench for simon_host_ctrl with a behavioural core stand-in that
// answers the published SIMON_9696 vectors and a simple transform otherwise.
module tb_simon_host_ctrl;

    localparam logic [95:0] K0 = 96'h0D0C0B0A0908050403020100;
    localparam logic [95:0] P0 = 96'h2072616C6C69702065687420;
    localparam logic [95:0] C0 = 96'h602807A462b469063D8FF082;
    localparam logic [95:0] X0 = 96'h00112233445566778899AABB;
    localparam logic [95:0] X1 = 96'hFEDCBA987654321000FF00FF;

    logic        clk = 1'b0;
    logic        nR;
    logic        key_valid;
    logic [95:0] key_in;
    logic        key_ready;
    logic        blk_valid;
    logic [95:0] blk_in;
    logic        blk_enc;
    logic        blk_ready;
    logic        res_valid;
    logic [95:0] res_data;
    logic        res_ready;
    logic        err;
    logic        newKey;
    logic [95:0] key;
    logic        ldKey;
    logic        doneKey;
    logic        newData;
    logic [95:0] plain;
    logic        enc_dec;
    logic        ldData;
    logic        doneData;
    logic        readData;
    logic [95:0] cipher;

    int checks   = 0;
    int failures = 0;

    simon_host_ctrl #(.N(48), .M(2), .TO(16)) dut (
        .clk       (clk),
        .nR        (nR),
        .key_valid (key_valid),
        .key_in    (key_in),
        .key_ready (key_ready),
        .blk_valid (blk_valid),
        .blk_in    (blk_in),
        .blk_enc   (blk_enc),
        .blk_ready (blk_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .err       (err),
        .newKey    (newKey),
        .key       (key),
        .ldKey     (ldKey),
        .doneKey   (doneKey),
        .newData   (newData),
        .plain     (plain),
        .enc_dec   (enc_dec),
        .ldData    (ldData),
        .doneData  (doneData),
        .readData  (readData),
        .cipher    (cipher)
    );

    always #5 clk = ~clk;

    // Core stand-in
    logic        no_ld;
    logic        key_done_flag;
    logic [95:0] core_key;
    logic [95:0] core_plain;
    logic        core_enc;
    int          ks, kd, ds, dd;

    function automatic logic [95:0] core_fn(input logic [95:0] k, input logic [95:0] p,
                                            input logic e);
        if (k == K0 && e && p == P0) return C0;
        if (k == K0 && !e && p == C0) return P0;
        return p ^ k ^ {96{e}};
    endfunction

    always @(posedge clk) begin
        ldKey   <= 1'b0;
        doneKey <= 1'b0;
        ldData  <= 1'b0;
        if (!nR) begin
            ks <= 0; kd <= 0; ds <= 0; dd <= 0;
            doneData <= 1'b0;
            cipher <= '0;
            key_done_flag <= 1'b0;
        end else begin
            case (ks)
                0: if (newKey) begin kd <= 2; ks <= 1; key_done_flag <= 1'b0; end
                1: if (kd == 0) begin ldKey <= 1'b1; core_key <= key; kd <= 3; ks <= 2; end
                   else kd <= kd - 1;
                2: if (kd == 0) begin doneKey <= 1'b1; key_done_flag <= 1'b1; ks <= 3; end
                   else kd <= kd - 1;
                default: ks <= 0;
            endcase
            case (ds)
                0: if (newData && !no_ld) begin dd <= 2; ds <= 1; end
                1: if (dd == 0) begin
                       ldData <= 1'b1; core_plain <= plain; core_enc <= enc_dec;
                       dd <= 3; ds <= 2;
                   end else dd <= dd - 1;
                2: if (dd == 0) begin
                       doneData <= 1'b1;
                       cipher <= core_fn(core_key, core_plain, core_enc);
                       ds <= 3;
                   end else dd <= dd - 1;
                default: if (readData) begin doneData <= 1'b0; ds <= 0; end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [95:0] k);
        int n = 0;
        key_in = k;
        key_valid = 1'b1;
        #1;
        while (!key_ready && n < 50) begin step(); n++; end
        chk("key_accept", key_ready, 1'b1);
        step();
        key_valid = 1'b0;
    endtask

    logic done_at_accept;

    task automatic take_block(input logic [95:0] b, input logic e);
        int n = 0;
        blk_in = b;
        blk_enc = e;
        blk_valid = 1'b1;
        #1;
        while (!blk_ready && n < 80) begin step(); n++; end
        chk("blk_accept", blk_ready, 1'b1);
        done_at_accept = key_done_flag;
        step();
        blk_valid = 1'b0;
    endtask

    task automatic finish_block(input string tag, input logic [95:0] exp);
        int n = 0;
        while (!res_valid && n < 80) begin step(); n++; end
        chk({tag, "_valid"}, res_valid, 1'b1);
        chk(tag, res_data, exp);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk({tag, "_drop"}, res_valid, 1'b0);
    endtask

    initial begin
        logic stall_ok;
        logic data_ok;
        logic no_blk;
        int   nd;

        nR = 1'b0; key_valid = 1'b1; key_in = K0; blk_valid = 1'b0; blk_in = '0;
        blk_enc = 1'b0; res_ready = 1'b0; no_ld = 1'b0;
        repeat (3) step();
        chk("rst_key_ready", key_ready, 1'b0);
        chk("rst_outs", {blk_ready, res_valid, err, newKey, newData, readData}, 6'b0);
        chk("rst_res_data", res_data, '0);
        key_valid = 1'b0;
        nR = 1'b1;
        step();

        // Block before any key must stall
        blk_in = P0; blk_enc = 1'b1; blk_valid = 1'b1;
        no_blk = 1'b1;
        repeat (6) begin step(); if (blk_ready) no_blk = 1'b0; end
        chk("blk_before_key", no_blk, 1'b1);

        // Key and block together: key wins, block waits for doneKey
        key_in = K0; key_valid = 1'b1;
        #1;
        chk("simul_key_ready", key_ready, 1'b1);
        chk("simul_blk_ready", blk_ready, 1'b0);
        step();
        key_valid = 1'b0;
        take_block(P0, 1'b1);
        chk("blk_after_donekey", done_at_accept, 1'b1);
        finish_block("enc_vec", C0);
        chk("core_key", core_key, K0);
        chk("core_plain_enc", {core_enc, core_plain}, {1'b1, P0});

        take_block(C0, 1'b0);
        finish_block("dec_vec", P0);
        chk("core_plain_dec", {core_enc, core_plain}, {1'b0, C0});

        take_block(X0, 1'b1);
        finish_block("xform_enc", X0 ^ K0 ^ {96{1'b1}});

        // Downstream backpressure for 20 cycles with a second block pending
        take_block(X1, 1'b0);
        nd = 0;
        while (!res_valid && nd < 80) begin step(); nd++; end
        blk_in = X0; blk_enc = 1'b1; blk_valid = 1'b1;
        stall_ok = 1'b1; data_ok = 1'b1; no_blk = 1'b1;
        repeat (20) begin
            #1;
            if (!res_valid) stall_ok = 1'b0;
            if (res_data !== (X1 ^ K0)) data_ok = 1'b0;
            if (blk_ready) no_blk = 1'b0;
            step();
        end
        chk("stall_valid", stall_ok, 1'b1);
        chk("stall_data", data_ok, 1'b1);
        chk("stall_blk_ready", no_blk, 1'b1);
        finish_block("stall_res", X1 ^ K0);
        take_block(X0, 1'b1);
        finish_block("after_stall", X0 ^ K0 ^ {96{1'b1}});

        // New key: blocks stall until its doneKey
        load_key(X1);
        take_block(X0, 1'b0);
        chk("rekey_block_wait", done_at_accept, 1'b1);
        finish_block("rekey_res", X0 ^ X1);

        // Watchdog: core never latches the block
        no_ld = 1'b1;
        take_block(P0, 1'b1);
        nd = 0;
        while (newData && nd < 40) begin step(); nd++; end
        chk("wd_cycles", nd, 16);
        chk("wd_err", err, 1'b1);
        chk("wd_strobes", {newData, readData, res_valid}, 3'b0);
        blk_valid = 1'b1;
        #1;
        chk("wd_key_unloaded", blk_ready, 1'b0);
        blk_valid = 1'b0;
        repeat (3) step();
        chk("wd_err_sticky", err, 1'b1);
        no_ld = 1'b0;
        nR = 1'b0;
        step();
        nR = 1'b1;
        step();
        chk("rst_clears_err", err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
